instr_prefetch_buffer: RTL and testbench

//  Instruction fetch front-end that feeds the RV32E IF stage from a pipelined, variable-latency

---
 rtl/instr_prefetch_buffer_pkg.sv | 25 ++
 rtl/instr_prefetch_buffer_sync_fifo.sv | 79 +++++++
 rtl/instr_prefetch_buffer.sv | 146 ++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_buffer_pkg
// Description : Shared types and constants for the instruction prefetch
//               front-end. This includes the fetch FSM state encoding and the
//               canonical RV32 NOP.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_prefetch_buffer_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Instruction word width
  localparam int INSTR_W = 32;

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with flush. It holds {pc, instr} entries for
//               the prefetch buffer. Push is accepted when full only if a pop
//               happens in the same cycle. Flush overrides push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointer and occupancy, with flush taking priority
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage writes (no reset needed, occupancy gates reads)
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_buffer
// Description : Instruction fetch front-end. It issues sequential word fetches
//               to a pipelined, variable-latency memory and buffers up to DEPTH
//               PC-tagged instructions for the IF stage. On a redirect it
//               flushes and discards in-flight responses before restarting.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  logic              credit_ok;
  logic              req_fire;
  logic              rsp_push;
  logic              inst_pop;
  logic [ADDR_W-1:0] boot_aligned;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              unused_addr_lsbs;

  assign boot_aligned     = {boot_addr[ADDR_W-1:2], 2'b00};
  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsbs = ^{boot_addr[1:0], redirect_pc[1:0]};

  // Fetch credit: in-flight words plus buffered words never exceed DEPTH,
  // so a response always finds room in the buffer.
  assign credit_ok     = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);
  assign mem_req_valid = !rst && (state_q == FETCH) && credit_ok && !redirect_valid;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses are dropped while old requests are being discarded, and also
  // in a redirect cycle.
  assign rsp_push = mem_rsp_valid && (discard_q == '0) && !redirect_valid;

  assign inst_valid = !fifo_empty && !redirect_valid && !rst;
  assign inst_pop   = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? fifo_rdata[INSTR_W-1:0] : NOP;
  assign inst_pc    = inst_valid ? fifo_rdata[ENTRY_W-1:INSTR_W] : '0;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .pop   (inst_pop),
    .flush (redirect_valid),
    .wdata ({rsp_pc_q, mem_rsp_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state for counters, PCs and FSM (redirect has highest priority)
  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    state_d       = state_q;

    if (req_fire && !mem_rsp_valid)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!req_fire && mem_rsp_valid) outstanding_d = outstanding_q - CNT_W'(1);

    if (mem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);

    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (rsp_push) rsp_pc_d   = rsp_pc_q + ADDR_W'(4);

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      // While draining, every in-flight word is already being discarded.
      if (state_q != DRAIN) discard_d = outstanding_d;
    end

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (redirect_valid && (outstanding_d != '0)) state_d = DRAIN;
      DRAIN:   if (discard_d == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= boot_aligned;
      rsp_pc_q      <= boot_aligned;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifndef SYNTHESIS
  // The credit scheme must keep responses away from a full buffer
  a_no_rsp_when_full : assert property (@(posedge clk) disable iff (rst)
    !(mem_rsp_valid && fifo_full));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_buffer
// Description : Self-checking bench for instr_prefetch_buffer. It uses an
//               in-order variable-latency memory, a queue-based reference model
//               and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] boot_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .boot_addr      (boot_addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  // Desired stimulus, applied at the next negedge
  logic        d_rst = 1'b1, d_redirect = 1'b0, d_req_ready = 1'b1, d_inst_ready = 1'b1;
  logic [31:0] d_boot = 32'h0000_1000, d_redirect_pc = '0;
  int          lat = 1;
  logic        redir_on_rsp = 1'b0, redir_hit = 1'b0;
  logic [31:0] redir_target = '0;

  // Memory environment: in-order pending requests
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;

  // Reference model
  logic [63:0] m_buf[$];
  int          m_outs = 0, m_disc = 0;
  logic [31:0] m_fetch = '0, m_rsp_pc = '0;
  logic        m_boot = 1'b1;

  // Samples and logs
  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_req_addr, s_inst_data, s_inst_pc;
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  int n_checks = 0, n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive, sample, compare against model, advance model
  task automatic cycle();
    logic        e_req_valid, e_inst_valid;
    logic [31:0] e_data, e_pc;
    logic [63:0] head;
    logic        exp_fire, exp_pop;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (!d_rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_addr[0]);
    end
    if (redir_on_rsp && mem_rsp_valid && m_buf.size() > 0) begin
      d_redirect    = 1'b1;
      d_redirect_pc = redir_target;
      redir_hit     = 1'b1;
    end
    rst            = d_rst;
    boot_addr      = d_boot;
    redirect_valid = d_redirect;
    redirect_pc    = d_redirect_pc;
    mem_req_ready  = d_req_ready;
    inst_ready     = d_inst_ready;
    #1;
    s_req_valid  = mem_req_valid;
    s_req_addr   = mem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_data  = inst_data;
    s_inst_pc    = inst_pc;

    // Expected outputs from the model
    e_req_valid  = !rst && !m_boot && (m_disc == 0) &&
                   (m_outs + m_buf.size() < DEPTH) && !redirect_valid;
    e_inst_valid = !rst && (m_buf.size() != 0) && !redirect_valid;
    head   = (m_buf.size() != 0) ? m_buf[0] : 64'd0;
    e_data = e_inst_valid ? head[31:0]  : NOP_W;
    e_pc   = e_inst_valid ? head[63:32] : 32'd0;
    chk("req_valid", 64'(s_req_valid), 64'(e_req_valid));
    if (e_req_valid) chk("req_addr", 64'(s_req_addr), 64'(m_fetch));
    chk("inst_valid", 64'(s_inst_valid), 64'(e_inst_valid));
    chk("inst_data", 64'(s_inst_data), 64'(e_data));
    chk("inst_pc", 64'(s_inst_pc), 64'(e_pc));

    if (mem_req_valid && mem_req_ready && !rst) req_log.push_back(mem_req_addr);
    if (inst_valid && inst_ready && !rst) pop_log.push_back(inst_pc);

    // Advance memory and model
    if (rst) begin
      pend_addr.delete(); pend_due.delete();
      m_buf.delete();
      m_outs = 0; m_disc = 0; m_boot = 1'b1;
      m_fetch  = {boot_addr[31:2], 2'b00};
      m_rsp_pc = {boot_addr[31:2], 2'b00};
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend_addr.push_back(mem_req_addr);
        pend_due.push_back(cyc + lat);
      end
      if (mem_rsp_valid) begin
        void'(pend_addr.pop_front()); void'(pend_due.pop_front());
      end
      exp_fire = e_req_valid && mem_req_ready;
      exp_pop  = e_inst_valid && inst_ready;
      if (exp_fire) begin m_outs++; m_fetch = m_fetch + 32'd4; end
      if (mem_rsp_valid) m_outs--;
      if (redirect_valid) begin
        m_buf.delete();
        m_disc   = m_outs;
        m_fetch  = {redirect_pc[31:2], 2'b00};
        m_rsp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_pop) void'(m_buf.pop_front());
        if (mem_rsp_valid) begin
          if (m_disc > 0) m_disc--;
          else begin
            m_buf.push_back({m_rsp_pc, mem_rsp_data});
            m_rsp_pc = m_rsp_pc + 32'd4;
          end
        end
      end
      m_boot = 1'b0;
    end
    d_redirect = 1'b0;
    cyc++;
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic do_reset(input logic [31:0] b);
    d_boot = b; d_rst = 1'b1;
    cycle();
    d_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; boot_addr = '0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;

    // Reset and sequential streaming at latency 1
    d_rst = 1'b1; d_boot = 32'h0000_1000; lat = 1; d_req_ready = 1'b1; d_inst_ready = 1'b1;
    cycle(); cycle();
    chk("rst_req_valid", 64'(s_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(s_inst_valid), 64'd0);
    chk("rst_inst_data", 64'(s_inst_data), 64'h13);
    chk("rst_inst_pc", 64'(s_inst_pc), 64'd0);
    d_rst = 1'b0; clear_logs();
    cycle();
    chk("boot_req_valid", 64'(s_req_valid), 64'd0);
    chk("boot_inst_valid", 64'(s_inst_valid), 64'd0);
    cycle(); cycle();
    n = 0;
    repeat (8) begin cycle(); if (s_inst_valid) n++; end
    chk("s1_no_gaps", 64'(n), 64'd8);
    chk("s1_req0", 64'(req_log[0]), 64'h1000);
    chk("s1_req1", 64'(req_log[1]), 64'h1004);
    chk("s1_pop0", 64'(pop_log[0]), 64'h1000);
    chk("s1_pop3", 64'(pop_log[3]), 64'h100C);

    // Consumer stalled: fill to DEPTH, then resume
    d_inst_ready = 1'b0;
    do_reset(32'h0000_1000); clear_logs();
    repeat (12) cycle();
    chk("s2_req_count", 64'(req_log.size()), 64'd4);
    chk("s2_full_no_req", 64'(s_req_valid), 64'd0);
    chk("s2_full_valid", 64'(s_inst_valid), 64'd1);
    d_inst_ready = 1'b1;
    cycle();
    chk("s2_pop_cycle_req", 64'(s_req_valid), 64'd0);
    chk("s2_pop_pc", 64'(s_inst_pc), 64'h1000);
    cycle();
    chk("s2_resume_req", 64'(s_req_valid), 64'd1);
    chk("s2_resume_addr", 64'(s_req_addr), 64'h1010);

    // Memory back-pressure holds the request
    d_req_ready = 1'b0;
    do_reset(32'h0000_1000);
    cycle();
    repeat (3) begin
      cycle();
      chk("s3_hold_valid", 64'(s_req_valid), 64'd1);
      chk("s3_hold_addr", 64'(s_req_addr), 64'h1000);
    end
    d_req_ready = 1'b1;
    cycle();
    chk("s3_fire_addr", 64'(s_req_addr), 64'h1000);
    cycle();
    chk("s3_next_addr", 64'(s_req_addr), 64'h1004);

    // Redirect with two requests in flight at latency 3
    lat = 3;
    do_reset(32'h0000_1000); clear_logs();
    cycle(); cycle(); cycle();
    chk("s4_inflight", 64'(req_log.size()), 64'd2);
    d_redirect = 1'b1; d_redirect_pc = 32'h0000_2002;
    cycle();
    chk("s4_redir_inst_valid", 64'(s_inst_valid), 64'd0);
    chk("s4_redir_req_valid", 64'(s_req_valid), 64'd0);
    clear_logs();
    cycle(); chk("s4_drain0", 64'(s_req_valid), 64'd0);
    cycle(); chk("s4_drain1", 64'(s_req_valid), 64'd0);
    cycle();
    chk("s4_restart_valid", 64'(s_req_valid), 64'd1);
    chk("s4_restart_addr", 64'(s_req_addr), 64'h2000);
    repeat (8) cycle();
    chk("s4_first_pc", 64'(pop_log[0]), 64'h2000);

    // Redirect colliding with a response and a pop
    lat = 1;
    do_reset(32'h0000_1000);
    repeat (6) cycle();
    redir_on_rsp = 1'b1; redir_target = 32'h0000_3000; redir_hit = 1'b0;
    for (int i = 0; i < 20 && !redir_hit; i++) cycle();
    redir_on_rsp = 1'b0;
    chk("s5_hit", 64'(redir_hit), 64'd1);
    chk("s5_same_cycle_valid", 64'(s_inst_valid), 64'd0);
    cycle();
    chk("s5_next_valid", 64'(s_inst_valid), 64'd0);
    chk("s5_next_addr", 64'(s_req_addr), 64'h3000);

    // Address wrap, then reset mid-stream
    d_redirect = 1'b1; d_redirect_pc = 32'hFFFF_FFFC;
    cycle(); clear_logs();
    repeat (6) cycle();
    chk("s6_wrap0", 64'(req_log[0]), 64'hFFFF_FFFC);
    chk("s6_wrap1", 64'(req_log[1]), 64'h0);
    d_boot = 32'h0000_0800; d_rst = 1'b1;
    cycle();
    chk("s6_rst_req", 64'(s_req_valid), 64'd0);
    d_rst = 1'b0;
    cycle();
    chk("s6_after_req", 64'(s_req_valid), 64'd0);
    chk("s6_after_inst", 64'(s_inst_valid), 64'd0);
    cycle();
    chk("s6_boot_addr", 64'(s_req_addr), 64'h800);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_req_ready  = ($urandom_range(0, 99) < 70);
      d_inst_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 3) begin
        d_redirect    = 1'b1;
        d_redirect_pc = $urandom;
      end
      if ($urandom_range(0, 199) == 0) begin
        d_rst  = 1'b1;
        d_boot = $urandom;
        lat    = $urandom_range(1, 4);
      end else begin
        d_rst = 1'b0;
      end
      cycle();
    end
    d_rst = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
